img_mem_stream_writer: RTL and testbench

Parametrised write-side address generator for the input image buffer. It accepts pixels over a valid/ready stream and issues one memory write per pixel. Addresses are generated in raster order per channel, and the channel index advances after each full plane. It sits between the HPS/Avalon pixel loader and the image RAM banks, and raises done when the whole multi-channel frame is stored.

---
 rtl/img_mem_stream_writer.sv | 204 ++++++++++++++++++++
 tb/tb_img_mem_stream_writer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/img_mem_stream_writer.sv
// -----------------------------------------------------------------------------
// img_mem_stream_writer
//
// Write-side address generator for the input image buffer. Pixels arrive on a
// valid/ready stream and each accepted pixel becomes exactly one registered
// memory write. Addresses run in raster order within a plane. The plane
// (channel) index advances after each full plane. done is raised once the
// whole multi-channel frame has been stored.
//
// Optional feature, macro IMG_WR_BASE_EN:
//   This feature adds base_addr_i. The base is latched on an accepted start.
//   mem_addr_o then becomes (base + pixel index) modulo 2^ADDR_W.
//
// Ports:
//   clk_i        rising-edge clock
//   reset_i      asynchronous, active-high reset
//   start_i      one-cycle pulse, begins a frame (ignored while writing)
//   abort_i      synchronous abort back to idle; a beat in the same cycle is dropped
//   in_valid_i   pixel valid
//   in_data_i    pixel value
//   base_addr_i  (IMG_WR_BASE_EN only) per-frame base address
//   in_ready_o   writer can accept a pixel (combinational from state)
//   mem_we_o     write strobe, one cycle per accepted pixel, 1-cycle latency
//   mem_addr_o   plane-relative pixel address
//   mem_ch_o     target plane / RAM bank
//   mem_wdata_o  pixel to write
//   busy_o       frame in progress
//   done_o       frame complete, sticky until next start or reset
// -----------------------------------------------------------------------------
module img_mem_stream_writer #(
    parameter  int IMG_W  = 28,
    parameter  int IMG_H  = 28,
    parameter  int NUM_CH = 1,
    parameter  int DATA_W = 8,
    localparam int ADDR_W = (IMG_W * IMG_H > 1) ? $clog2(IMG_W * IMG_H) : 1,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic              in_valid_i,
    input  logic [DATA_W-1:0] in_data_i,
`ifdef IMG_WR_BASE_EN
    input  logic [ADDR_W-1:0] base_addr_i,
`endif
    output logic              in_ready_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [CH_W-1:0]   mem_ch_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic              busy_o,
    output logic              done_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Terminal counts at full counter width, so a non-power-of-two plane
    // wraps at its real size and never drives an out-of-plane address.
    localparam logic [ADDR_W-1:0] PIX_LAST = ADDR_W'(IMG_W * IMG_H - 1);
    localparam logic [CH_W-1:0]   CH_LAST  = CH_W'(NUM_CH - 1);

    state_t              state_q,  state_d;
    logic [ADDR_W-1:0]   pix_q,    pix_d;
    logic [CH_W-1:0]     ch_q,     ch_d;
    logic                busy_q,   busy_d;
    logic                done_q,   done_d;
    logic                we_q,     we_d;
    logic [ADDR_W-1:0]   addr_q,   addr_d;
    logic [CH_W-1:0]     mch_q,    mch_d;
    logic [DATA_W-1:0]   wdata_q,  wdata_d;
`ifdef IMG_WR_BASE_EN
    logic [ADDR_W-1:0]   base_q,   base_d;
`endif

    logic                in_ready_s;
    logic                accept_s;
    logic [ADDR_W-1:0]   wr_addr_s;

    assign in_ready_s = (state_q == ST_WRITE);
    assign accept_s   = in_valid_i & in_ready_s;

    // The address sum is truncated to ADDR_W, which gives the modulo wrap.
`ifdef IMG_WR_BASE_EN
    assign wr_addr_s = base_q + pix_q;
`else
    assign wr_addr_s = pix_q;
`endif

    // State and output registers, cleared asynchronously by reset.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            pix_q   <= '0;
            ch_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            mch_q   <= '0;
            wdata_q <= '0;
`ifdef IMG_WR_BASE_EN
            base_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            pix_q   <= pix_d;
            ch_q    <= ch_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            mch_q   <= mch_d;
            wdata_q <= wdata_d;
`ifdef IMG_WR_BASE_EN
            base_q  <= base_d;
`endif
        end
    end

    // Next-state, counter and registered-output logic; abort overrides all.
    always_comb begin
        state_d = state_q;
        pix_d   = pix_q;
        ch_d    = ch_q;
        busy_d  = busy_q;
        done_d  = done_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        mch_d   = mch_q;
        wdata_d = wdata_q;
`ifdef IMG_WR_BASE_EN
        base_d  = base_q;
`endif
        if (abort_i) begin
            state_d = ST_IDLE;
            pix_d   = '0;
            ch_d    = '0;
            busy_d  = 1'b0;
            done_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start_i) begin
                        state_d = ST_WRITE;
                        pix_d   = '0;
                        ch_d    = '0;
                        busy_d  = 1'b1;
                        done_d  = 1'b0;
`ifdef IMG_WR_BASE_EN
                        base_d  = base_addr_i;
`endif
                    end else begin
                        state_d = state_q;
                    end
                end
                ST_WRITE: begin
                    if (accept_s) begin
                        we_d    = 1'b1;
                        addr_d  = wr_addr_s;
                        mch_d   = ch_q;
                        wdata_d = in_data_i;
                        if (pix_q != PIX_LAST) begin
                            pix_d = pix_q + ADDR_W'(1);
                        end else begin
                            pix_d = '0;
                            if (ch_q != CH_LAST) begin
                                ch_d = ch_q + CH_W'(1);
                            end else begin
                                // Final beat: done and busy change with the last write.
                                ch_d    = '0;
                                state_d = ST_DONE;
                                busy_d  = 1'b0;
                                done_d  = 1'b1;
                            end
                        end
                    end else begin
                        state_d = ST_WRITE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    pix_d   = '0;
                    ch_d    = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b0;
                end
            endcase
        end
    end

    assign in_ready_o  = in_ready_s;
    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_ch_o    = mch_q;
    assign mem_wdata_o = wdata_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;

endmodule

// File: tb/tb_img_mem_stream_writer.sv
// -----------------------------------------------------------------------------
// Bench for img_mem_stream_writer. It drives two instances from the same
// stimulus: the default 28x28x1 geometry and a 4x4x3 multi-plane geometry.
// Expected writes come from a beat-count model. Beat k of a frame is written
// at ((base + k mod plane) mod 2^ADDR_W) on channel k / plane.
// -----------------------------------------------------------------------------
module tb_img_mem_stream_writer;

    logic       clk    = 1'b0;
    logic       reset  = 1'b1;
    logic       start  = 1'b0;
    logic       abort  = 1'b0;
    logic       valid  = 1'b0;
    logic [7:0] data   = 8'd0;
    logic [9:0] base_v = 10'd0;

    logic       a_ready, a_we, a_ch, a_busy, a_done;
    logic [9:0] a_addr;
    logic [7:0] a_wd;
    logic       b_ready, b_we, b_busy, b_done;
    logic [3:0] b_addr;
    logic [1:0] b_ch;
    logic [7:0] b_wd;

    int n_checks = 0;
    int n_fail   = 0;

    img_mem_stream_writer u_a (
        .clk_i       (clk),
        .reset_i     (reset),
        .start_i     (start),
        .abort_i     (abort),
        .in_valid_i  (valid),
        .in_data_i   (data),
`ifdef IMG_WR_BASE_EN
        .base_addr_i (base_v),
`endif
        .in_ready_o  (a_ready),
        .mem_we_o    (a_we),
        .mem_addr_o  (a_addr),
        .mem_ch_o    (a_ch),
        .mem_wdata_o (a_wd),
        .busy_o      (a_busy),
        .done_o      (a_done)
    );

    img_mem_stream_writer #(.IMG_W(4), .IMG_H(4), .NUM_CH(3), .DATA_W(8)) u_b (
        .clk_i       (clk),
        .reset_i     (reset),
        .start_i     (start),
        .abort_i     (abort),
        .in_valid_i  (valid),
        .in_data_i   (data),
`ifdef IMG_WR_BASE_EN
        .base_addr_i (base_v[3:0]),
`endif
        .in_ready_o  (b_ready),
        .mem_we_o    (b_we),
        .mem_addr_o  (b_addr),
        .mem_ch_o    (b_ch),
        .mem_wdata_o (b_wd),
        .busy_o      (b_busy),
        .done_o      (b_done)
    );

    always #5 clk = ~clk;

    // Reference model state, index 0 = 28x28x1, index 1 = 4x4x3.
    int plane [2] = '{784, 16};
    int nch   [2] = '{1, 3};
    int aw    [2] = '{10, 4};
    int m_k   [2] = '{0, 0};
    int m_base[2] = '{0, 0};
    bit m_act [2] = '{1'b0, 1'b0};
    bit m_busy[2] = '{1'b0, 1'b0};
    bit m_done[2] = '{1'b0, 1'b0};
    bit e_we  [2] = '{1'b0, 1'b0};
    int e_addr[2] = '{0, 0};
    int e_ch  [2] = '{0, 0};
    int e_wd  [2] = '{0, 0};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Predict the effect of the coming clock edge from the current inputs.
    task automatic model_edge(input int id);
        if (abort) begin
            m_act[id] = 1'b0; m_k[id] = 0; m_busy[id] = 1'b0; m_done[id] = 1'b0;
            e_we[id] = 1'b0;
        end else if (!m_act[id] && start) begin
            m_act[id] = 1'b1; m_k[id] = 0; m_busy[id] = 1'b1; m_done[id] = 1'b0;
            m_base[id] = int'(base_v) % (1 << aw[id]);
            e_we[id] = 1'b0;
        end else if (m_act[id] && valid) begin
            e_we[id]   = 1'b1;
            e_addr[id] = (m_base[id] + m_k[id] % plane[id]) % (1 << aw[id]);
            e_ch[id]   = m_k[id] / plane[id];
            e_wd[id]   = int'(data);
            m_k[id]++;
            if (m_k[id] == plane[id] * nch[id]) begin
                m_act[id] = 1'b0; m_busy[id] = 1'b0; m_done[id] = 1'b1;
            end
        end else begin
            e_we[id] = 1'b0;
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_act[i] = 1'b0; m_k[i] = 0; m_busy[i] = 1'b0; m_done[i] = 1'b0;
            e_we[i] = 1'b0;
        end
    endtask

    task automatic check_outs();
        chk("a_we",   32'(a_we),   32'(e_we[0]));
        if (e_we[0]) begin
            chk("a_addr", 32'(a_addr), 32'(e_addr[0]));
            chk("a_ch",   32'(a_ch),   32'(e_ch[0]));
            chk("a_wd",   32'(a_wd),   32'(e_wd[0]));
        end
        chk("a_busy", 32'(a_busy), 32'(m_busy[0]));
        chk("a_done", 32'(a_done), 32'(m_done[0]));
        chk("b_we",   32'(b_we),   32'(e_we[1]));
        if (e_we[1]) begin
            chk("b_addr", 32'(b_addr), 32'(e_addr[1]));
            chk("b_ch",   32'(b_ch),   32'(e_ch[1]));
            chk("b_wd",   32'(b_wd),   32'(e_wd[1]));
        end
        chk("b_busy", 32'(b_busy), 32'(m_busy[1]));
        chk("b_done", 32'(b_done), 32'(m_done[1]));
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_a_ready"}, 32'(a_ready), 32'd0);
        chk({tag, "_a_we"},    32'(a_we),    32'd0);
        chk({tag, "_a_addr"},  32'(a_addr),  32'd0);
        chk({tag, "_a_ch"},    32'(a_ch),    32'd0);
        chk({tag, "_a_wd"},    32'(a_wd),    32'd0);
        chk({tag, "_a_busy"},  32'(a_busy),  32'd0);
        chk({tag, "_a_done"},  32'(a_done),  32'd0);
        chk({tag, "_b_ready"}, 32'(b_ready), 32'd0);
        chk({tag, "_b_we"},    32'(b_we),    32'd0);
        chk({tag, "_b_addr"},  32'(b_addr),  32'd0);
        chk({tag, "_b_ch"},    32'(b_ch),    32'd0);
        chk({tag, "_b_busy"},  32'(b_busy),  32'd0);
        chk({tag, "_b_done"},  32'(b_done),  32'd0);
    endtask

    // One clock cycle: drive at negedge, check ready, predict, check after posedge.
    task automatic step(input bit v, input bit s, input bit ab);
        @(negedge clk);
        valid = v;
        start = s;
        abort = ab;
        data  = 8'($urandom);
        #1;
        chk("a_ready", 32'(a_ready), 32'(m_act[0]));
        chk("b_ready", 32'(b_ready), 32'(m_act[1]));
        model_edge(0);
        model_edge(1);
        @(posedge clk);
        #1;
        check_outs();
    endtask

    // Asynchronous reset in the middle of a cycle, with a valid beat pending.
    task automatic do_reset();
        @(negedge clk);
        valid = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_all_zero("rst_async");
        @(posedge clk);
        #1;
        check_outs();
        @(negedge clk);
        reset = 1'b0;
        valid = 1'b0;
    endtask

    initial begin
        int n;
        #3;
        check_all_zero("rst_init");
        @(negedge clk);
        reset = 1'b0;

        // Full frame with valid held high; the 785th beat must be refused.
        step(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 790; i++) step(1'b1, 1'b0, 1'b0);
        chk("t1_a_done", 32'(a_done), 32'd1);
        chk("t1_b_done", 32'(b_done), 32'd1);

        // Restart after done, toggling valid, with extra starts mid-frame.
        step(1'b0, 1'b1, 1'b0);
        n = 0;
        while (!m_done[0] && n < 4000) begin
            step(1'($urandom % 2), (n == 100 || n == 200), 1'b0);
            n++;
        end
        chk("t2_bound", 32'(n < 4000), 32'd1);
        chk("t2_a_done", 32'(a_done), 32'd1);

        // Reset mid-frame, then a fresh frame restarts at address 0.
        step(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 300; i++) step(1'b1, 1'b0, 1'b0);
        do_reset();
        step(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 50; i++) step(1'b1, 1'b0, 1'b0);

        // Abort together with an accepted beat, then abort together with start.
        step(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        chk("t5_a_busy", 32'(a_busy), 32'd0);

`ifdef IMG_WR_BASE_EN
        // Base latched on start; a later change must not matter.
        base_v = 10'd1000;
        step(1'b0, 1'b1, 1'b0);
        base_v = 10'd5;
        for (int i = 0; i < 30; i++) step(1'b1, 1'b0, 1'b0);
        n = 0;
        while (!m_done[0] && n < 2000) begin
            step(1'b1, 1'b0, 1'b0);
            n++;
        end
        chk("base_bound", 32'(n < 2000), 32'd1);
        base_v = 10'd0;
`endif

        // Start after done on both instances gives a fresh frame.
        step(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
